dmem_access: RTL and testbench

DMEM_ACCESS -- requirements
Module: dmem_access

---
 rtl/rv32i_types.sv | 54 +++++
 rtl/dmem_access_if.sv | 37 +++
 rtl/dmem_load_extend.sv | 32 +++
 rtl/dmem_access.sv | 135 +++++++++++++
 tb/tb_dmem_access.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I encodings and data-memory access types.
// Imported by the MEM-stage access unit and its helpers.
package rv32i_types;

  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    lbu = 3'b100,
    lhu = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010
  } store_funct3_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } dmem_state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } dmem_size_t;

  // Access width; any funct3 not naming a byte or half is a word.
  function automatic dmem_size_t dmem_size(
    input logic       is_load,
    input logic [2:0] f3
  );
    dmem_size_t s;
    s = SZ_W;
    if (is_load) begin
      case (f3)
        lb, lbu: s = SZ_B;
        lh, lhu: s = SZ_H;
        default: s = SZ_W;
      endcase
    end else begin
      case (f3)
        sb:      s = SZ_B;
        sh:      s = SZ_H;
        default: s = SZ_W;
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/dmem_access_if.sv
// Pipeline-side and memory-side signals of the MEM-stage access unit.
// slave is the access unit, master is whatever drives it.
interface dmem_access_if;
  logic        valid_i;
  logic        data_read;
  logic        data_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        mem_resp;
  logic [31:0] mem_rdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_enable;
  logic        stall;
  logic [31:0] load_data;
  logic        done;
  logic        misalign;

  modport slave (
    input  valid_i, data_read, data_write, funct3,
    input  addr, store_data, mem_resp, mem_rdata,
    output mem_read, mem_write, mem_address, mem_wdata,
    output mem_byte_enable, stall, load_data, done,
    output misalign
  );

  modport master (
    output valid_i, data_read, data_write, funct3,
    output addr, store_data, mem_resp, mem_rdata,
    input  mem_read, mem_write, mem_address, mem_wdata,
    input  mem_byte_enable, stall, load_data, done,
    input  misalign
  );
endinterface

// File: rtl/dmem_load_extend.sv
// Selects the addressed byte/half of a memory word and
// sign- or zero-extends it to 32 bits.
module dmem_load_extend
  import rv32i_types::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] word_i,
  output logic [31:0] result_o
);

  logic [31:0] sh_w;
  logic [7:0]  b;
  logic [15:0] h;

  assign sh_w = word_i >> {offset_i, 3'b000};
  assign b    = sh_w[7:0];
  assign h    = offset_i[1] ? word_i[31:16] : word_i[15:0];

  // Extend the selected lane; unknown funct3 passes the word.
  always_comb begin
    result_o = word_i;
    case (funct3_i)
      lb:      result_o = {{24{b[7]}}, b};
      lbu:     result_o = {24'd0, b};
      lh:      result_o = {{16{h[15]}}, h};
      lhu:     result_o = {16'd0, h};
      default: result_o = word_i;
    endcase
  end

endmodule

// File: rtl/dmem_access.sv
// MEM-stage data-memory access unit: issues one registered
// load/store, waits for mem_resp, returns extended load data.
module dmem_access
  import rv32i_types::*;
(
  input  logic          clk,
  input  logic          rst,
  dmem_access_if.slave  bus
);

  dmem_state_t state_q, state_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        done_q, done_d;
  logic [31:0] load_q, load_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;

  logic        req;
  logic        misaligned;
  dmem_size_t  sz;
  logic [3:0]  be_new;
  logic [31:0] ext;

  assign req = bus.valid_i & (bus.data_read | bus.data_write);
  assign sz  = dmem_size(bus.data_read, bus.funct3);

  assign misaligned =
    ((sz == SZ_W) && (bus.addr[1:0] != 2'b00)) ||
    ((sz == SZ_H) && bus.addr[0]);

  // Lane mask for the incoming request; reads fetch the whole word.
  always_comb begin
    be_new = 4'b1111;
    if (!bus.data_read) begin
      unique case (1'b1)
        (sz == SZ_B): be_new = 4'b0001 << bus.addr[1:0];
        (sz == SZ_H): be_new = 4'b0011 << bus.addr[1:0];
        default:      be_new = 4'b1111;
      endcase
    end
  end

  dmem_load_extend u_ext (
    .funct3_i (f3_q),
    .offset_i (off_q),
    .word_i   (bus.mem_rdata),
    .result_o (ext)
  );

  // Next-state and next-output logic of the access FSM.
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    done_d  = 1'b0;
    load_d  = load_q;
    f3_d    = f3_q;
    off_d   = off_q;
    unique case (state_q)
      IDLE: begin
        if (req && !misaligned) begin
          state_d = ACCESS;
          rd_d    = bus.data_read;
          wr_d    = ~bus.data_read;
          addr_d  = {bus.addr[31:2], 2'b00};
          wdata_d = bus.store_data << {bus.addr[1:0], 3'b000};
          be_d    = be_new;
          f3_d    = bus.funct3;
          off_d   = bus.addr[1:0];
        end
      end
      ACCESS: begin
        if (bus.mem_resp) begin
          state_d = DONE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          done_d  = 1'b1;
          if (rd_q) load_d = ext;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      done_q  <= 1'b0;
      load_q  <= '0;
      f3_q    <= '0;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      done_q  <= done_d;
      load_q  <= load_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
    end
  end

  assign bus.mem_read        = rd_q;
  assign bus.mem_write       = wr_q;
  assign bus.mem_address     = addr_q;
  assign bus.mem_wdata       = wdata_q;
  assign bus.mem_byte_enable = be_q;
  assign bus.done            = done_q;
  assign bus.load_data       = load_q;
  assign bus.misalign        = (state_q == IDLE) & req & misaligned;
  assign bus.stall           =
    ((state_q == IDLE) & req & ~misaligned) | (state_q == ACCESS);

endmodule

// File: tb/tb_dmem_access.sv
// Scoreboard bench for dmem_access: expected transactions are
// queued when driven and retired when the unit signals done.
module tb_dmem_access;
  import rv32i_types::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_access_if bus();

  dmem_access dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        rd;
    logic [31:0] maddr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] ld;
  } exp_t;

  exp_t        sbq[$];
  exp_t        me;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] model_ld = 32'd0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] m_be(input logic rd,
                                      input logic [2:0] f3,
                                      input logic [1:0] off);
    if (rd) return 4'hF;
    if (f3 == 3'b000) return 4'b0001 << off;
    if (f3 == 3'b001) return 4'b0011 << off;
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_ld(input logic [2:0] f3,
                                       input logic [1:0] off,
                                       input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = w[{off[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'd0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  task automatic push_exp(input logic rd, input logic [2:0] f3,
                          input logic [31:0] a,
                          input logic [31:0] sd,
                          input logic [31:0] rdata);
    exp_t e;
    e.rd    = rd;
    e.maddr = {a[31:2], 2'b00};
    e.wdata = sd << {a[1:0], 3'b000};
    e.be    = m_be(rd, f3, a[1:0]);
    if (rd) model_ld = m_ld(f3, a[1:0], rdata);
    e.ld    = model_ld;
    sbq.push_back(e);
  endtask

  task automatic drive(input logic rd, input logic wr,
                       input logic [2:0] f3,
                       input logic [31:0] a,
                       input logic [31:0] sd);
    bus.valid_i    = 1'b1;
    bus.data_read  = rd;
    bus.data_write = wr;
    bus.funct3     = f3;
    bus.addr       = a;
    bus.store_data = sd;
  endtask

  task automatic txn(input logic rd, input logic wr,
                     input logic [2:0] f3,
                     input logic [31:0] a,
                     input logic [31:0] sd,
                     input logic [31:0] rdata,
                     input int k);
    @(negedge clk);
    drive(rd, wr, f3, a, sd);
    bus.mem_resp = 1'b0;
    push_exp(rd, f3, a, sd, rdata);
    #1;
    check("stall_req", 32'(bus.stall), 32'd1);
    check("misalign_ok", 32'(bus.misalign), 32'd0);
    for (int c = 1; c <= k; c++) begin
      @(negedge clk);
      #1;
      check("stall_acc", 32'(bus.stall), 32'd1);
      check("rd_strobe", 32'(bus.mem_read), 32'(rd));
      check("wr_strobe", 32'(bus.mem_write), 32'(!rd));
      if (c == k) begin
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = rdata;
      end
    end
    @(negedge clk);
    bus.mem_resp  = 1'b0;
    bus.valid_i   = 1'b0;
    bus.mem_rdata = $urandom;
    #1;
    check("done_set", 32'(bus.done), 32'd1);
    check("stall_done", 32'(bus.stall), 32'd0);
    check("strobes_off",
          32'({bus.mem_read, bus.mem_write}), 32'd0);
    @(negedge clk);
    #1;
    check("done_clr", 32'(bus.done), 32'd0);
  endtask

  logic prev_done = 1'b0;

  always @(negedge clk) begin
    if (bus.mem_read || bus.mem_write) begin
      if (sbq.size() == 0) begin
        check("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        me = sbq[0];
        check("mon_rd", 32'(bus.mem_read), 32'(me.rd));
        check("mon_addr", bus.mem_address, me.maddr);
        check("mon_wdata", bus.mem_wdata, me.wdata);
        check("mon_be", 32'(bus.mem_byte_enable), 32'(me.be));
      end
    end
    if (bus.done) begin
      if (sbq.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        me = sbq.pop_front();
        check("mon_load", bus.load_data, me.ld);
      end
    end
  end

  initial begin
    rst            = 1'b1;
    bus.valid_i    = 1'b0;
    bus.data_read  = 1'b0;
    bus.data_write = 1'b0;
    bus.funct3     = 3'b000;
    bus.addr       = 32'd0;
    bus.store_data = 32'd0;
    bus.mem_resp   = 1'b0;
    bus.mem_rdata  = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_read", 32'(bus.mem_read), 32'd0);
    check("rst_write", 32'(bus.mem_write), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_addr", bus.mem_address, 32'd0);
    check("rst_wdata", bus.mem_wdata, 32'd0);
    check("rst_be", 32'(bus.mem_byte_enable), 32'd0);
    check("rst_load", bus.load_data, 32'd0);
    check("rst_stall", 32'(bus.stall), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    txn(1'b0, 1'b1, sw, 32'h100, 32'hDEADBEEF, 32'h0, 3);
    txn(1'b0, 1'b1, sb, 32'h103, 32'h000000AB, 32'h0, 1);
    txn(1'b0, 1'b1, sh, 32'h102, 32'h0000C0DE, 32'h0, 2);
    txn(1'b1, 1'b0, lb, 32'h102, 32'h0, 32'h12F45678, 1);
    check("lb_lit", bus.load_data, 32'hFFFFFFF4);
    txn(1'b1, 1'b0, lbu, 32'h102, 32'h0, 32'h12F45678, 2);
    check("lbu_lit", bus.load_data, 32'h000000F4);
    txn(1'b1, 1'b0, lhu, 32'h102, 32'h0, 32'h12F45678, 1);
    check("lhu_lit", bus.load_data, 32'h000012F4);
    txn(1'b1, 1'b0, lh, 32'h100, 32'h0, 32'h00008001, 1);
    check("lh_lit", bus.load_data, 32'hFFFF8001);
    txn(1'b1, 1'b0, lw, 32'h104, 32'h0, 32'hCAFEF00D, 2);
    txn(1'b0, 1'b1, sw, 32'h108, 32'h11223344, 32'h0, 1);
    check("load_hold", bus.load_data, 32'hCAFEF00D);
    txn(1'b1, 1'b1, lw, 32'h10C, 32'h0, 32'h0BADCAFE, 1);
    txn(1'b1, 1'b0, 3'b110, 32'h110, 32'h0, 32'h80000001, 1);
    txn(1'b0, 1'b1, 3'b011, 32'h114, 32'hA5A5A5A5, 32'h0, 1);

    @(negedge clk);
    drive(1'b1, 1'b0, lw, 32'h101, 32'h0);
    #1;
    check("mis_lw_flag", 32'(bus.misalign), 32'd1);
    check("mis_lw_stall", 32'(bus.stall), 32'd0);
    @(negedge clk);
    #1;
    check("mis_lw_nostb",
          32'({bus.mem_read, bus.mem_write}), 32'd0);
    check("mis_lw_idle", 32'(bus.misalign), 32'd1);
    drive(1'b0, 1'b1, sh, 32'h101, 32'h0);
    #1;
    check("mis_sh_flag", 32'(bus.misalign), 32'd1);
    check("mis_sh_stall", 32'(bus.stall), 32'd0);
    @(negedge clk);
    bus.valid_i = 1'b0;
    #1;
    check("mis_sh_nostb",
          32'({bus.mem_read, bus.mem_write}), 32'd0);

    bus.mem_resp  = 1'b1;
    bus.mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    bus.mem_resp = 1'b0;
    #1;
    check("idle_resp_done", 32'(bus.done), 32'd0);
    check("idle_resp_load", bus.load_data, model_ld);

    @(negedge clk);
    drive(1'b0, 1'b1, sw, 32'h200, 32'h12345678);
    push_exp(1'b0, sw, 32'h200, 32'h12345678, 32'h0);
    @(negedge clk);
    rst         = 1'b1;
    bus.valid_i = 1'b0;
    #1;
    check("rst_acc_stb", 32'(bus.mem_write), 32'd1);
    @(negedge clk);
    rst          = 1'b0;
    bus.mem_resp = 1'b1;
    sbq.delete();
    model_ld = 32'd0;
    #1;
    check("abort_stb",
          32'({bus.mem_read, bus.mem_write}), 32'd0);
    check("abort_addr", bus.mem_address, 32'd0);
    check("abort_wdata", bus.mem_wdata, 32'd0);
    check("abort_be", 32'(bus.mem_byte_enable), 32'd0);
    check("abort_load", bus.load_data, 32'd0);
    check("abort_stall", 32'(bus.stall), 32'd0);
    @(negedge clk);
    bus.mem_resp = 1'b0;
    #1;
    check("abort_nodone", 32'(bus.done), 32'd0);
    check("abort_stall2", 32'(bus.stall), 32'd0);

    @(negedge clk);
    drive(1'b1, 1'b0, lw, 32'h120, 32'h0);
    push_exp(1'b1, lw, 32'h120, 32'h0, 32'h01020304);
    @(negedge clk);
    #1;
    check("b2b_rd", 32'(bus.mem_read), 32'd1);
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = 32'h01020304;
    @(negedge clk);
    bus.mem_resp = 1'b0;
    drive(1'b0, 1'b1, sw, 32'h124, 32'h000055AA);
    push_exp(1'b0, sw, 32'h124, 32'h000055AA, 32'h0);
    #1;
    check("b2b_done1", 32'(bus.done), 32'd1);
    check("b2b_stall_dn", 32'(bus.stall), 32'd0);
    check("b2b_nowr_dn", 32'(bus.mem_write), 32'd0);
    @(negedge clk);
    #1;
    check("b2b_nowr_idle", 32'(bus.mem_write), 32'd0);
    check("b2b_stall_req", 32'(bus.stall), 32'd1);
    check("b2b_done_clr", 32'(bus.done), 32'd0);
    @(negedge clk);
    #1;
    check("b2b_wr", 32'(bus.mem_write), 32'd1);
    check("b2b_no_rd", 32'(bus.mem_read), 32'd0);
    bus.mem_resp = 1'b1;
    @(negedge clk);
    bus.mem_resp = 1'b0;
    bus.valid_i  = 1'b0;
    #1;
    check("b2b_done2", 32'(bus.done), 32'd1);
    check("b2b_load", bus.load_data, 32'h01020304);
    @(negedge clk);
    #1;

    check("sb_empty", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
